// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: generic inter-stage register with valid/ready handshake,
// 2-entry skid buffer (registered in_ready) and synchronous flush.
// Optional build macro: PIPE_STAGE_STATS_EN enables the stall_cycles counter;
// without it stall_cycles is tied to zero.
module pipe_stage_skid #(
  parameter int unsigned         DATA_W   = 32,
  parameter int unsigned         ADDR_W   = 14,
  parameter logic [DATA_W-1:0]   NOP_WORD = 32'h00000000
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [ADDR_W-1:0] in_ret_addr,
  input  logic              in_take_branch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_ret_addr,
  output logic              out_take_branch,
  output logic [1:0]        occupancy,
  output logic [15:0]       stall_cycles
);

  localparam int unsigned PW = DATA_W + ADDR_W + 1;

  // State encoding doubles as the occupancy count.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  // MAIN holds the bubble value whenever the stage is empty, so outputs come
  // straight from registers with no valid-gating mux.
  localparam logic [PW-1:0] BUBBLE = {NOP_WORD, {ADDR_W{1'b0}}, 1'b0};

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] main_q, main_d;
  logic [PW-1:0] skid_q, skid_d;
  logic          in_ready_q;
  logic          accept;
  logic          drain;

  assign accept = in_valid & in_ready_q;
  assign drain  = out_valid & out_ready;

  // Next-state and payload movement between input, MAIN and SKID.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = BUBBLE;
      skid_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = {in_instr, in_ret_addr, in_take_branch};
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_d = {in_instr, in_ret_addr, in_take_branch};
          end else if (accept) begin
            skid_d  = {in_instr, in_ret_addr, in_take_branch};
            state_d = FULL;
          end else if (drain) begin
            main_d  = BUBBLE;
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            main_d  = skid_q;
            skid_d  = '0;
            state_d = ONE;
          end
        end
        default: begin
          main_d  = BUBBLE;
          skid_d  = '0;
          state_d = EMPTY;
        end
      endcase
    end
  end

  // State, payload slots and the registered ready flag.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_q    <= EMPTY;
      main_q     <= BUBBLE;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  assign in_ready        = in_ready_q;
  assign out_valid       = (state_q != EMPTY);
  assign occupancy       = state_q;
  assign out_instr       = main_q[PW-1 -: DATA_W];
  assign out_ret_addr    = main_q[ADDR_W:1];
  assign out_take_branch = main_q[0];

`ifdef PIPE_STAGE_STATS_EN
  logic [15:0] stall_q;

  // Saturating count of cycles where a valid beat is held back downstream.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      stall_q <= '0;
    end else if (flush) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed vector table, stall sequence and a
// randomized run, all checked against a queue-based reference model.
module tb_pipe_stage_skid;

  logic        clock;
  logic        nreset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [13:0] in_ret_addr;
  logic        in_take_branch;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [13:0] out_ret_addr;
  logic        out_take_branch;
  logic [1:0]  occupancy;
  logic [15:0] stall_cycles;

  pipe_stage_skid #(
    .DATA_W   (32),
    .ADDR_W   (14),
    .NOP_WORD (32'h00000000)
  ) dut (
    .clock           (clock),
    .nreset          (nreset),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_instr        (in_instr),
    .in_ret_addr     (in_ret_addr),
    .in_take_branch  (in_take_branch),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_ret_addr    (out_ret_addr),
    .out_take_branch (out_take_branch),
    .occupancy       (occupancy),
    .stall_cycles    (stall_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: the stage is a FIFO of capacity two.
  typedef struct packed {
    logic [31:0] i;
    logic [13:0] a;
    logic        b;
  } beat_t;

  beat_t       mq[$];
  int unsigned m_stall = 0;

  task automatic model_edge(input logic r, input logic f, input logic v,
                            input beat_t nb, input logic ordy);
    int unsigned sz;
    bit          acc;
    bit          drn;
    sz  = mq.size();
    acc = v && (sz < 2);
    drn = (sz > 0) && ordy;
    if (!r) begin
      mq.delete();
      m_stall = 0;
    end else begin
      if (sz > 0 && !ordy && m_stall < 65535) m_stall++;
      if (f) begin
        mq.delete();
        m_stall = 0;
      end else begin
        if (drn) void'(mq.pop_front());
        if (acc) mq.push_back(nb);
      end
    end
  endtask

  task automatic model_check();
    logic [15:0] exp_stall;
`ifdef PIPE_STAGE_STATS_EN
    exp_stall = m_stall[15:0];
`else
    exp_stall = 16'h0000;
`endif
    chk("m_out_valid", {63'd0, out_valid}, {63'd0, mq.size() > 0});
    chk("m_in_ready", {63'd0, in_ready}, {63'd0, mq.size() < 2});
    chk("m_occupancy", {62'd0, occupancy}, 64'(mq.size()));
    if (mq.size() > 0) begin
      chk("m_out_instr", {32'd0, out_instr}, {32'd0, mq[0].i});
      chk("m_out_ret", {50'd0, out_ret_addr}, {50'd0, mq[0].a});
      chk("m_out_br", {63'd0, out_take_branch}, {63'd0, mq[0].b});
    end else begin
      chk("m_bubble_instr", {32'd0, out_instr}, 64'h0);
      chk("m_bubble_ret", {50'd0, out_ret_addr}, 64'h0);
      chk("m_bubble_br", {63'd0, out_take_branch}, 64'h0);
    end
    chk("m_stall", {48'd0, stall_cycles}, {48'd0, exp_stall});
  endtask

  // One clock: drive inputs, advance model at the edge, check #1 later.
  task automatic step(input logic r, input logic f, input logic v,
                      input logic [31:0] ins, input logic [13:0] ra,
                      input logic br, input logic ordy);
    beat_t nb;
    nreset = r; flush = f; in_valid = v; in_instr = ins;
    in_ret_addr = ra; in_take_branch = br; out_ready = ordy;
    nb = '{i: ins, a: ra, b: br};
    @(posedge clock);
    model_edge(r, f, v, nb, ordy);
    #1;
    model_check();
  endtask

  typedef struct {
    logic        r, f, v;
    logic [31:0] ins;
    logic [13:0] ra;
    logic        br, ordy;
    logic        ev;
    logic [31:0] ei;
    logic [13:0] ea;
    logic        eb;
    logic [1:0]  eocc;
    logic        erdy;
  } vec_t;

  vec_t tbl[15];

  initial begin
    nreset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0;
    in_ret_addr = '0; in_take_branch = 1'b0; out_ready = 1'b0;

    //            r  f  v  instr          ra       br ordy  ev  ei            ea       eb occ   rdy
    tbl[0]  = '{1'b0,1'b0,1'b1,32'h55555555,14'h0000,1'b0,1'b0, 1'b0,32'h00000000,14'h0000,1'b0,2'd0,1'b1};
    tbl[1]  = '{1'b0,1'b0,1'b1,32'h55555555,14'h0000,1'b0,1'b0, 1'b0,32'h00000000,14'h0000,1'b0,2'd0,1'b1};
    tbl[2]  = '{1'b1,1'b0,1'b1,32'h11111111,14'h0000,1'b0,1'b1, 1'b1,32'h11111111,14'h0000,1'b0,2'd1,1'b1};
    tbl[3]  = '{1'b1,1'b0,1'b1,32'h22222222,14'h0000,1'b0,1'b1, 1'b1,32'h22222222,14'h0000,1'b0,2'd1,1'b1};
    tbl[4]  = '{1'b1,1'b0,1'b1,32'h33333333,14'h0000,1'b0,1'b1, 1'b1,32'h33333333,14'h0000,1'b0,2'd1,1'b1};
    tbl[5]  = '{1'b1,1'b0,1'b0,32'h00000000,14'h0000,1'b0,1'b1, 1'b0,32'h00000000,14'h0000,1'b0,2'd0,1'b1};
    tbl[6]  = '{1'b1,1'b0,1'b1,32'hA0000001,14'h0000,1'b0,1'b0, 1'b1,32'hA0000001,14'h0000,1'b0,2'd1,1'b1};
    tbl[7]  = '{1'b1,1'b0,1'b1,32'hA0000002,14'h0000,1'b0,1'b0, 1'b1,32'hA0000001,14'h0000,1'b0,2'd2,1'b0};
    tbl[8]  = '{1'b1,1'b0,1'b1,32'hA0000003,14'h0000,1'b0,1'b0, 1'b1,32'hA0000001,14'h0000,1'b0,2'd2,1'b0};
    tbl[9]  = '{1'b1,1'b0,1'b0,32'h00000000,14'h0000,1'b0,1'b1, 1'b1,32'hA0000002,14'h0000,1'b0,2'd1,1'b1};
    tbl[10] = '{1'b1,1'b0,1'b0,32'h00000000,14'h0000,1'b0,1'b1, 1'b0,32'h00000000,14'h0000,1'b0,2'd0,1'b1};
    tbl[11] = '{1'b1,1'b0,1'b1,32'h12345678,14'h1ABC,1'b1,1'b0, 1'b1,32'h12345678,14'h1ABC,1'b1,2'd1,1'b1};
    tbl[12] = '{1'b1,1'b0,1'b1,32'hBBBB0001,14'h0000,1'b0,1'b0, 1'b1,32'h12345678,14'h1ABC,1'b1,2'd2,1'b0};
    tbl[13] = '{1'b1,1'b1,1'b1,32'hDEADBEEF,14'h0000,1'b0,1'b0, 1'b0,32'h00000000,14'h0000,1'b0,2'd0,1'b1};
    tbl[14] = '{1'b1,1'b0,1'b0,32'h00000000,14'h0000,1'b0,1'b1, 1'b0,32'h00000000,14'h0000,1'b0,2'd0,1'b1};

    for (int k = 0; k < 15; k++) begin
      step(tbl[k].r, tbl[k].f, tbl[k].v, tbl[k].ins, tbl[k].ra, tbl[k].br, tbl[k].ordy);
      chk($sformatf("v%0d_out_valid", k), {63'd0, out_valid}, {63'd0, tbl[k].ev});
      chk($sformatf("v%0d_out_instr", k), {32'd0, out_instr}, {32'd0, tbl[k].ei});
      chk($sformatf("v%0d_out_ret", k), {50'd0, out_ret_addr}, {50'd0, tbl[k].ea});
      chk($sformatf("v%0d_out_br", k), {63'd0, out_take_branch}, {63'd0, tbl[k].eb});
      chk($sformatf("v%0d_occ", k), {62'd0, occupancy}, {62'd0, tbl[k].eocc});
      chk($sformatf("v%0d_in_ready", k), {63'd0, in_ready}, {63'd0, tbl[k].erdy});
    end

    // Stall counter: one held beat, five blocked cycles, then flush.
    step(1'b1, 1'b0, 1'b1, 32'hC0DE0001, 14'h0001, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, 32'h0, 14'h0, 1'b0, 1'b0);
`ifdef PIPE_STAGE_STATS_EN
    chk("stall_after5", {48'd0, stall_cycles}, 64'd5);
`else
    chk("stall_tied0", {48'd0, stall_cycles}, 64'd0);
`endif
    chk("stall_hold_instr", {32'd0, out_instr}, 64'hC0DE0001);
    step(1'b1, 1'b1, 1'b0, 32'h0, 14'h0, 1'b0, 1'b0);
    chk("stall_flush_clr", {48'd0, stall_cycles}, 64'd0);
    chk("flush_empty", {62'd0, occupancy}, 64'd0);

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 59) != 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 2) != 0, $urandom, 14'($urandom),
           1'($urandom), $urandom_range(0, 2) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
